// File: rtl/xadc_pair_reader.sv
// XADC two-channel DRP reader: on each end-of-conversion it reads channel A then channel B,
// optionally averages 2^AVG_LOG2 pairs and publishes both codes with a one-cycle strobe.
module xadc_pair_reader #(
    parameter logic [6:0]  CH_A_ADDR = 7'h13,
    parameter logic [6:0]  CH_B_ADDR = 7'h1B,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned AVG_LOG2  = 0
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic        eoc_in,
    output logic        drp_den,
    output logic [6:0]  drp_daddr,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic [11:0] volt_out_a,
    output logic [11:0] volt_out_b,
    output logic        drdy_out,
    output logic        timeout_err,
    output logic [7:0]  overrun_cnt
);

    localparam int unsigned AW = 12 + AVG_LOG2;
    localparam int unsigned CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ_A  = 3'd1;
    localparam logic [2:0] ST_WAIT_A = 3'd2;
    localparam logic [2:0] ST_REQ_B  = 3'd3;
    localparam logic [2:0] ST_WAIT_B = 3'd4;
    localparam logic [2:0] ST_ACC    = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [6:0]    r_daddr;
    logic [11:0]   r_samp_a;
    logic [11:0]   r_samp_b;
    logic [AW-1:0] r_acc_a;
    logic [AW-1:0] r_acc_b;
    logic [CW-1:0] r_cnt;
    logic          r_pending;
    logic [7:0]    r_wait;
    logic [11:0]   r_volt_a;
    logic [11:0]   r_volt_b;
    logic          r_drdy;
    logic          r_timeout_err;
    logic [7:0]    r_overrun;

    logic          w_in_wait;
    logic          w_timeout;
    logic          w_last;
    logic [AW-1:0] w_acc_a_new;
    logic [AW-1:0] w_acc_b_new;
    logic [11:0]   w_avg_a;
    logic [11:0]   w_avg_b;
    logic          w_unused_do;

    assign w_in_wait   = (r_state == ST_WAIT_A) || (r_state == ST_WAIT_B);
    // A same-cycle drp_drdy takes priority over the timeout.
    assign w_timeout   = w_in_wait && !drp_drdy && (r_wait == WAIT_LAST);
    assign w_last      = (r_cnt == CNT_LAST);
    assign w_acc_a_new = r_acc_a + AW'(r_samp_a);
    assign w_acc_b_new = r_acc_b + AW'(r_samp_b);
    assign w_avg_a     = w_acc_a_new[AVG_LOG2 +: 12];
    assign w_avg_b     = w_acc_b_new[AVG_LOG2 +: 12];
    assign w_unused_do = ^drp_do[3:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (eoc_in || r_pending) w_state_nxt = ST_REQ_A;
            ST_REQ_A:  w_state_nxt = ST_WAIT_A;
            ST_WAIT_A: begin
                if (drp_drdy) begin
                    w_state_nxt = ST_REQ_B;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ_B:  w_state_nxt = ST_WAIT_B;
            ST_WAIT_B: begin
                if (drp_drdy) begin
                    w_state_nxt = ST_ACC;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACC:    w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            r_state       <= ST_IDLE;
            r_daddr       <= CH_A_ADDR;
            r_samp_a      <= '0;
            r_samp_b      <= '0;
            r_acc_a       <= '0;
            r_acc_b       <= '0;
            r_cnt         <= '0;
            r_pending     <= 1'b0;
            r_wait        <= '0;
            r_volt_a      <= '0;
            r_volt_b      <= '0;
            r_drdy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overrun     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drdy  <= 1'b0;

            if (w_state_nxt == ST_REQ_A) begin
                r_daddr <= CH_A_ADDR;
            end else if (w_state_nxt == ST_REQ_B) begin
                r_daddr <= CH_B_ADDR;
            end

            r_wait <= w_in_wait ? r_wait + 8'd1 : 8'd0;

            if (r_state == ST_WAIT_A && drp_drdy) r_samp_a <= drp_do[15:4];
            if (r_state == ST_WAIT_B && drp_drdy) r_samp_b <= drp_do[15:4];

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
                r_acc_a       <= '0;
                r_acc_b       <= '0;
                r_cnt         <= '0;
            end

            if (r_state == ST_ACC) begin
                if (w_last) begin
                    r_volt_a <= w_avg_a;
                    r_volt_b <= w_avg_b;
                    r_drdy   <= 1'b1;
                    r_acc_a  <= '0;
                    r_acc_b  <= '0;
                    r_cnt    <= '0;
                end else begin
                    r_acc_a <= w_acc_a_new;
                    r_acc_b <= w_acc_b_new;
                    r_cnt   <= r_cnt + CW'(1);
                end
            end

            // One-deep EOC queue; IDLE always consumes whatever is waiting.
            if (r_state == ST_IDLE) begin
                r_pending <= 1'b0;
            end else if (eoc_in) begin
                if (!r_pending) begin
                    r_pending <= 1'b1;
                end else if (r_overrun != 8'hFF) begin
                    r_overrun <= r_overrun + 8'd1;
                end
            end
        end
    end

    assign drp_den     = (r_state == ST_REQ_A) || (r_state == ST_REQ_B);
    assign drp_daddr   = r_daddr;
    assign drp_dwe     = 1'b0;
    assign drp_di      = 16'h0000;
    assign volt_out_a  = r_volt_a;
    assign volt_out_b  = r_volt_b;
    assign drdy_out    = r_drdy;
    assign timeout_err = r_timeout_err;
    assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_xadc_pair_reader.sv
// Bench for xadc_pair_reader: two instances (no averaging and 4-deep averaging) share one XADC
// model; results are compared against a conversion-level reference model.
module tb_xadc_pair_reader;

    localparam logic [6:0] ADDR_A = 7'h13;
    localparam logic [6:0] ADDR_B = 7'h1B;
    localparam int AVG_N = 4;

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic        eoc_in = 1'b0;
    logic [15:0] drp_do = 16'h0000;
    logic        drp_drdy = 1'b0;

    logic        den0, dwe0, dr0, te0, den1, dwe1, dr1, te1;
    logic [6:0]  addr0, addr1;
    logic [15:0] di0, di1;
    logic [11:0] va0, vb0, va1, vb1;
    logic [7:0]  ov0, ov1;

    xadc_pair_reader #(.AVG_LOG2(0)) u_dut0 (
        .clk(clk), .reset_in(reset_in), .eoc_in(eoc_in), .drp_den(den0), .drp_daddr(addr0),
        .drp_dwe(dwe0), .drp_di(di0), .drp_do(drp_do), .drp_drdy(drp_drdy), .volt_out_a(va0),
        .volt_out_b(vb0), .drdy_out(dr0), .timeout_err(te0), .overrun_cnt(ov0)
    );

    xadc_pair_reader #(.AVG_LOG2(2)) u_dut1 (
        .clk(clk), .reset_in(reset_in), .eoc_in(eoc_in), .drp_den(den1), .drp_daddr(addr1),
        .drp_dwe(dwe1), .drp_di(di1), .drp_do(drp_do), .drp_drdy(drp_drdy), .volt_out_a(va1),
        .volt_out_b(vb1), .drdy_out(dr1), .timeout_err(te1), .overrun_cnt(ov1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // XADC model configuration and state
    int          lat = 1;
    logic        drop_a = 1'b0;
    logic [11:0] code_a = 12'd0;
    logic [11:0] code_b = 12'd0;
    logic [3:0]  nib = 4'd0;
    int          x_cd = 0;
    logic [6:0]  x_addr = ADDR_A;
    int          b_drdy_cnt = 0;
    int          b_drdy_cyc = 0;

    typedef struct {
        int         c;
        logic [6:0] a;
    } den_t;
    den_t den_log[$];
    int   pulse_cyc0[$];
    int   pulses0 = 0;
    int   pulses1 = 0;
    int   last_pulse0 = 0;
    logic prev_den = 1'b0;
    logic prev_dr0 = 1'b0;
    logic prev_dr1 = 1'b0;

    // XADC responder and per-cycle monitor
    initial begin
        forever begin
            @(negedge clk);
            drp_drdy = 1'b0;
            drp_do   = 16'($urandom);
            if (x_cd > 0) begin
                x_cd--;
                if (x_cd == 0) begin
                    drp_drdy = 1'b1;
                    drp_do   = {(x_addr == ADDR_B) ? code_b : code_a, nib};
                    if (x_addr == ADDR_B) begin
                        b_drdy_cnt++;
                        b_drdy_cyc = cyc;
                    end
                end
            end
            if (den0) begin
                check_eq("den_outstanding", x_cd, 0);
                den_log.push_back('{c: cyc, a: addr0});
                if (!(drop_a && addr0 == ADDR_A)) begin
                    x_cd   = lat;
                    x_addr = addr0;
                end
            end
            check_eq("den_single", prev_den & den0, 0);
            check_eq("den_match", {den1, addr1}, {den0, addr0});
            check_eq("dwe_di", {dwe0, di0, dwe1, di1}, 0);
            check_eq("drdy_consec", {prev_dr0 & dr0, prev_dr1 & dr1}, 0);
            prev_den = den0;
            prev_dr0 = dr0;
            prev_dr1 = dr1;
            if (dr0) begin
                pulses0++;
                last_pulse0 = cyc;
                pulse_cyc0.push_back(cyc);
            end
            if (dr1) pulses1++;
        end
    end

    // Conversion-level reference model
    logic [11:0] m0_va, m0_vb, m1_va, m1_vb;
    int m_n, m_sa, m_sb, exp_p0, exp_p1;

    function automatic void model_abort();
        m_n  = 0;
        m_sa = 0;
        m_sb = 0;
    endfunction

    function automatic void model_reset();
        model_abort();
        m0_va = 0; m0_vb = 0; m1_va = 0; m1_vb = 0;
    endfunction

    function automatic void model_conv(input int a, input int b);
        m0_va = 12'(a);
        m0_vb = 12'(b);
        exp_p0++;
        m_sa += a;
        m_sb += b;
        m_n++;
        if (m_n == AVG_N) begin
            m1_va = 12'(m_sa / AVG_N);
            m1_vb = 12'(m_sb / AVG_N);
            exp_p1++;
            model_abort();
        end
    endfunction

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_pulses0"}, pulses0, exp_p0);
        check_eq({tag, "_pulses1"}, pulses1, exp_p1);
        check_eq({tag, "_volt0"}, {va0, vb0}, {m0_va, m0_vb});
        check_eq({tag, "_volt1"}, {va1, vb1}, {m1_va, m1_vb});
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_den"}, {den0, den1}, 0);
        check_eq({tag, "_addr"}, {addr0, addr1}, {ADDR_A, ADDR_A});
        check_eq({tag, "_volt"}, {va0, vb0, va1, vb1}, 0);
        check_eq({tag, "_flags"}, {dr0, dr1, te0, te1}, 0);
        check_eq({tag, "_ovr"}, {ov0, ov1}, 0);
    endtask

    task automatic wait_den(input logic [6:0] addr);
        logic ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (den0 && addr0 == addr) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        check_eq("wait_den", ok, 1);
    endtask

    // Starts at a negedge with the DUT idle; one full conversion pair.
    task automatic run_conv(input int a, input int b, input int l, input string tag);
        int   start = pulses0;
        int   t0;
        logic got = 1'b0;
        code_a = 12'(a);
        code_b = 12'(b);
        lat    = l;
        den_log.delete();
        eoc_in = 1'b1;
        t0     = cyc;
        cycle();
        eoc_in = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (pulses0 != start) begin
                got = 1'b1;
                break;
            end
            cycle();
        end
        check_eq({tag, "_done"}, got, 1);
        model_conv(a, b);
        check_eq({tag, "_latency"}, last_pulse0 - t0, 2 * l + 4);
        check_eq({tag, "_b_to_drdy"}, last_pulse0 - b_drdy_cyc, 2);
        check_eq({tag, "_nden"}, den_log.size(), 2);
        check_eq({tag, "_addrs"}, (den_log.size() >= 2) ? {den_log[0].a, den_log[1].a} : 14'd0,
                 {ADDR_A, ADDR_B});
        check_eq({tag, "_den_a_cyc"}, (den_log.size() >= 1) ? den_log[0].c : -1, t0 + 1);
        check_outputs(tag);
    endtask

    initial begin
        int start, n, k, quiet, p0, p1;
        model_reset();
        exp_p0 = 0;
        exp_p1 = 0;
        repeat (3) cycle();
        reset_in = 1'b0;
        check_reset("reset");

        // Averaging: three silent conversions, then the mean of four
        for (int i = 0; i < 4; i++) begin
            nib = 4'($urandom);
            run_conv(3100 + 4 * i, 3200, $urandom_range(1, 3), "avg");
        end
        check_eq("avg_value", {va1, vb1}, {12'd3106, 12'd3200});

        // Basic read with the 3-cycle XADC model
        nib = 4'h0;
        run_conv(12'hC4E, 12'hC80, 3, "basic");
        check_eq("basic_value", {va0, vb0}, {12'd3150, 12'd3200});

        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) cycle();
            nib = 4'($urandom);
            run_conv($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(1, 6), "rand");
        end

        // EOC while busy: one during WAIT_A queues, one during WAIT_B overruns
        code_a = 12'($urandom);
        code_b = 12'($urandom);
        lat = 3;
        den_log.delete();
        pulse_cyc0.delete();
        start = pulses0;
        eoc_in = 1'b1;
        cycle();
        eoc_in = 1'b0;
        wait_den(ADDR_A);
        cycle();
        eoc_in = 1'b1;
        cycle();
        eoc_in = 1'b0;
        wait_den(ADDR_B);
        cycle();
        eoc_in = 1'b1;
        cycle();
        eoc_in = 1'b0;
        for (int i = 0; i < 300 && pulses0 < start + 2; i++) cycle();
        model_conv(code_a, code_b);
        model_conv(code_a, code_b);
        check_outputs("busy");
        check_eq("busy_overrun", {ov0, ov1}, {8'd1, 8'd1});
        check_eq("busy_req_a2", (den_log.size() >= 3 && pulse_cyc0.size() >= 1) ?
                 den_log[2].c - pulse_cyc0[0] : -1, 1);
        repeat (20) cycle();
        check_eq("busy_nden", den_log.size(), 4);
        check_outputs("busy_idle");

        // Continuous EOC drives the overrun count into saturation
        code_a = 12'($urandom);
        code_b = 12'($urandom);
        lat = $urandom_range(1, 4);
        start = b_drdy_cnt;
        eoc_in = 1'b1;
        repeat (500) cycle();
        eoc_in = 1'b0;
        quiet = 0;
        for (int i = 0; i < 400 && quiet < 30; i++) begin
            cycle();
            quiet = den0 ? 0 : quiet + 1;
        end
        check_eq("burst_quiet", quiet >= 30, 1);
        k = b_drdy_cnt - start;
        for (int i = 0; i < k; i++) model_conv(code_a, code_b);
        check_outputs("burst");
        check_eq("burst_overrun", {ov0, ov1}, {8'd255, 8'd255});

        // DRP timeout on the A read; averaging restarts afterwards
        run_conv($urandom_range(0, 4095), $urandom_range(0, 4095), 2, "pre_to");
        run_conv($urandom_range(0, 4095), $urandom_range(0, 4095), 2, "pre_to");
        drop_a = 1'b1;
        den_log.delete();
        p0 = pulses0;
        p1 = pulses1;
        eoc_in = 1'b1;
        n = cyc;
        cycle();
        eoc_in = 1'b0;
        while (cyc < n + 65) cycle();
        check_eq("to_early", {te0, te1}, 0);
        cycle();
        check_eq("to_flag", {te0, te1}, 2'b11);
        check_eq("to_no_drdy", {pulses0 - p0, pulses1 - p1}, 0);
        check_eq("to_nden", den_log.size(), 1);
        drop_a = 1'b0;
        model_abort();
        for (int i = 0; i < 4; i++) begin
            run_conv($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(1, 4),
                     "post_to");
        end
        check_eq("to_sticky", {te0, te1}, 2'b11);

        // Reset during WAIT_B, followed by the late drp_drdy
        code_a = 12'($urandom);
        code_b = 12'($urandom);
        lat = 3;
        den_log.delete();
        eoc_in = 1'b1;
        cycle();
        eoc_in = 1'b0;
        wait_den(ADDR_B);
        cycle();
        reset_in = 1'b1;
        cycle();
        reset_in = 1'b0;
        check_reset("mid_reset");
        model_reset();
        den_log.delete();
        repeat (8) cycle();
        check_eq("late_drdy_nden", den_log.size(), 0);
        check_outputs("late_drdy");
        run_conv($urandom_range(0, 4095), $urandom_range(0, 4095), 1, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
